// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master side issues requests; the slave side is the subtractor itself.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, in_a, in_b, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, in_a, in_b, bin,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = in_a - in_b - bin, one bit per clock,
// LSB first, with a single borrow flop. Operands are captured on the accepting
// edge, so the requester may change them freely afterwards. All outputs are
// driven straight from flops; diff/bout only move on the final RUN edge.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             bit_a;
    logic             bit_b;
    logic             bit_d;
    logic             br_next;
    logic [WIDTH-1:0] res_shift;
    logic             last_bit;

    // Single-bit full subtractor on the current LSBs plus the stored borrow.
    always_comb begin
        bit_a     = a_q[0];
        bit_b     = b_q[0];
        bit_d     = bit_a ^ bit_b ^ br_q;
        br_next   = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);
        res_shift = res_q >> 1;
        res_shift[WIDTH-1] = bit_d;
        last_bit  = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // Next-state logic for the IDLE -> RUN -> DONE sequencer and datapath.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    br_d    = bus.bin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = res_shift;
                br_d  = br_next;
                cnt_d = cnt_q + CNT_W'(1);
                // The final bit lands directly in diff so the result appears
                // on the same edge that raises done.
                if (last_bit) begin
                    diff_d  = res_shift;
                    bout_d  = br_next;
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset drops everything to zero at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive checks of the 4-bit serial subtractor.
module tb_serial_subtractor;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   cyc;

    serial_subtractor_if #(.WIDTH(4)) bus ();

    serial_subtractor #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One full transaction from IDLE; operands are scrambled after acceptance.
    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic bi,
                         output logic [3:0] d, output logic bo,
                         output int lat, output int bcnt);
        logic [3:0] prev;
        int         unstable;
        prev     = bus.diff;
        unstable = 0;
        bus.start = 1'b1;
        bus.in_a  = a;
        bus.in_b  = b;
        bus.bin   = bi;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.in_a  = ~a;
        bus.in_b  = ~b;
        bus.bin   = ~bi;
        lat  = 0;
        bcnt = 0;
        while (!bus.done && lat < 20) begin
            if (bus.busy) bcnt++;
            if (bus.diff !== prev) unstable++;
            @(posedge clk); #1;
            lat++;
        end
        d  = bus.diff;
        bo = bus.bout;
        chk("diff_stable_in_run", unstable, 0);
        @(posedge clk); #1;
        chk("done_one_cycle", bus.done, 1'b0);
    endtask

    logic [3:0] tab_a [5] = '{4'd9, 4'd5, 4'd0, 4'd15, 4'd15};
    logic [3:0] tab_b [5] = '{4'd5, 4'd9, 4'd0, 4'd15, 4'd0};
    logic       tab_c [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] tab_d [5] = '{4'h4, 4'hC, 4'hF, 4'h0, 4'hE};
    logic       tab_o [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    logic [3:0] bb_a [4] = '{4'd1, 4'd8, 4'd14, 4'd6};
    logic [3:0] bb_b [4] = '{4'd2, 4'd3, 4'd14, 4'd9};
    logic       bb_c [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0] bb_d [4] = '{4'hF, 4'h4, 4'hF, 4'hD};
    logic       bb_o [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        logic [3:0] d;
        logic       bo;
        int         lat;
        int         bcnt;
        int         n;
        int         dones;
        int         last_cyc;
        logic [4:0] ref_full;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.in_a  = 4'd0;
        bus.in_b  = 4'd0;
        bus.bin   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_diff", bus.diff, 4'd0);
        chk("rst_bout", bus.bout, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", bus.busy, 1'b0);

        // Directed vectors with latency and busy-width checks.
        for (int i = 0; i < 5; i++) begin
            do_op(tab_a[i], tab_b[i], tab_c[i], d, bo, lat, bcnt);
            chk("dir_diff", d, tab_d[i]);
            chk("dir_bout", bo, tab_o[i]);
            chk("dir_latency", lat, 4);
            chk("dir_busy_cycles", bcnt, 4);
        end

        // Exhaustive sweep against the unsigned reference.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    do_op(4'(a), 4'(b), 1'(c), d, bo, lat, bcnt);
                    ref_full = 5'(a) - 5'(b) - 5'(c);
                    chk("sweep_diff", d, ref_full[3:0]);
                    chk("sweep_bout", bo, (a < b + c) ? 1'b1 : 1'b0);
                end
            end
        end

        // start held through RUN/DONE is only taken once back in IDLE.
        bus.start = 1'b1;
        bus.in_a  = 4'd3;
        bus.in_b  = 4'd1;
        bus.bin   = 1'b0;
        @(posedge clk); #1;
        chk("hold_busy_up", bus.busy, 1'b1);
        bus.in_a = 4'd7;
        bus.in_b = 4'd7;
        n = 0;
        while (!bus.done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("hold_first_lat", n, 4);
        chk("hold_first_diff", bus.diff, 4'd2);
        chk("hold_first_bout", bus.bout, 1'b0);
        @(posedge clk); #1;
        chk("hold_idle_busy", bus.busy, 1'b0);
        chk("hold_idle_done", bus.done, 1'b0);
        @(posedge clk); #1;
        chk("hold_second_busy", bus.busy, 1'b1);
        bus.start = 1'b0;
        n = 0;
        while (!bus.done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("hold_second_lat", n, 4);
        chk("hold_second_diff", bus.diff, 4'd0);
        chk("hold_second_bout", bus.bout, 1'b0);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of RUN.
        do_op(4'd9, 4'd5, 1'b0, d, bo, lat, bcnt);
        chk("pre_rst_diff", d, 4'd4);
        bus.start = 1'b1;
        bus.in_a  = 4'd2;
        bus.in_b  = 4'd7;
        bus.bin   = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("midrun_busy", bus.busy, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 1'b0);
        chk("arst_done", bus.done, 1'b0);
        chk("arst_diff", bus.diff, 4'd0);
        chk("arst_bout", bus.bout, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) dones++;
        end
        chk("arst_no_activity", dones, 0);
        do_op(4'd12, 4'd3, 1'b1, d, bo, lat, bcnt);
        chk("post_rst_diff", d, 4'd8);
        chk("post_rst_bout", bo, 1'b0);
        chk("post_rst_lat", lat, 4);

        // Back-to-back with start held high.
        bus.start = 1'b1;
        bus.in_a  = bb_a[0];
        bus.in_b  = bb_b[0];
        bus.bin   = bb_c[0];
        last_cyc  = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!bus.busy && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            chk("b2b_accept_lat", n, (k == 0) ? 1 : 2);
            if (k < 3) begin
                bus.in_a = bb_a[k+1];
                bus.in_b = bb_b[k+1];
                bus.bin  = bb_c[k+1];
            end else begin
                bus.in_a = 4'hA;
                bus.in_b = 4'h5;
                bus.bin  = 1'b1;
            end
            n = 0;
            while (!bus.done && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            chk("b2b_run_lat", n, 4);
            chk("b2b_diff", bus.diff, bb_d[k]);
            chk("b2b_bout", bus.bout, bb_o[k]);
            if (k > 0) chk("b2b_period", cyc - last_cyc, 6);
            last_cyc = cyc;
        end
        bus.start = 1'b0;
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor with borrow-in and a start/busy/done handshake. It computes in_a − in_b − bin one bit per clock, LSB first, using a single borrow flip-flop. It is the inverse-operation companion to the combinational single-bit full adder in the ripple-carry exercise. It sits beside the adder as a low-area arithmetic unit for datapaths that can tolerate multi-cycle latency.

## Interface
- WIDTH, default 4: operand and result width in bits; must be ≥ 1.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- in_a  input  WIDTH  minuend; captured on the accepting edge.
- in_b  input  WIDTH  subtrahend; captured on the accepting edge.
- bin  input  1  borrow-in; captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; diff/bout are updated in the same cycle.
- diff  output  WIDTH  registered difference, held until the next result.
- bout  output  1  registered borrow-out (1 = unsigned underflow), held with diff.

## Operation
- State machine IDLE → RUN → DONE → IDLE. Reset state is IDLE.
- Reset values: busy=0, done=0, diff=0, bout=0. Internal shift registers, bit counter and borrow flip-flop also reset to 0.
- IDLE with start=1 at an edge: load the a/b shift registers from in_a/in_b, load borrow from bin, clear the counter, go to RUN. start=0: stay in IDLE.
- RUN, per edge:
  - With a0/b0 the current LSBs and br the stored borrow:
    - d = a0 ^ b0 ^ br
    - br' = (~a0 & b0) | (~(a0 ^ b0) & br)
  - Shift a and b right by one.
  - Shift d into the MSB of the internal result register, which shifts right.
  - Increment the counter.
  - On the edge processing bit WIDTH−1: copy the result register to diff and br' to bout, then go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE on the next edge.
- start is ignored in RUN and DONE. No queueing; a request is lost unless start is held until IDLE.
- diff and bout change only on the RUN→DONE edge. They are stable throughout RUN.
- Arithmetic is modulo 2^WIDTH: diff = (in_a − in_b − bin) mod 2^WIDTH; bout = 1 iff in_a < in_b + bin as unsigned values.
- Reset mid-operation (rst_n low in any state): immediate return to IDLE with all outputs at reset values. The partial result is discarded.
- in_a, in_b and bin may change freely after the accepting edge without affecting the result.

## Timing
- Let edge 0 be the edge that samples start=1 in IDLE.
- busy rises after edge 0 and falls after edge WIDTH.
- Bit i is processed at edge i+1, for i = 0..WIDTH−1.
- diff, bout and done are valid after edge WIDTH; done falls after edge WIDTH+1.
- Earliest next acceptance is edge WIDTH+2 (state IDLE after edge WIDTH+1).
- Throughput: one operation per WIDTH+2 cycles.
- No combinational path from any input to any output. All outputs are registered.
- rst_n assertion is asynchronous. Deassertion is assumed to be synchronized externally to clk.

## Test plan
- WIDTH=4, a=9, b=5, bin=0 → after 4 RUN cycles done pulses once with diff=4, bout=0; busy high exactly 4 cycles.
- a=5, b=9, bin=0 → diff=0xC, bout=1; a=0, b=0, bin=1 → diff=0xF, bout=1.
- a=15, b=15, bin=0 → diff=0, bout=0; a=15, b=0, bin=1 → diff=14, bout=0. Exhaustive sweep of all 512 (a, b, bin) combinations against the reference model (a−b−bin) mod 16 and the borrow flag.
- start pulsed with a=3, b=1, then start held with a=7, b=7 during RUN and DONE → only the first result (diff=2, bout=0) is produced. The held request is accepted at the first IDLE edge and yields diff=0, bout=0.
- rst_n asserted after 2 RUN cycles → busy, done, diff and bout drop to 0 immediately. No done pulse follows. A new start after release completes normally.
- Back-to-back: start kept high continuously with changing operands → done pulses every WIDTH+2 cycles; each diff matches the operands sampled on its own accepting edge.
